// File: rtl/mux_bus_responder_if.sv
// Bus-side signal bundle for mux_bus_responder.
// The multiplexed DATA_ADDR_LOW line is not part of this bundle. It is a
// bidirectional pin and stays a plain inout port on the responder.
interface mux_bus_responder_if;
  logic        E_IN;
  logic        RW;
  logic        AS;
  logic [7:0]  AD_HIGH;
  logic [7:0]  readData;
  logic        readStrobe;
  logic        wordValid;
  logic [15:0] wordAddress;
  logic [15:0] wordData;
  logic        pairError;

  // Responder side: samples the CPU bus and host read byte, reports words.
  modport slave (
    input  E_IN, RW, AS, AD_HIGH, readData,
    output readStrobe, wordValid, wordAddress, wordData, pairError
  );

  // Bus/host side: drives the CPU strobes and consumes the reports.
  modport master (
    output E_IN, RW, AS, AD_HIGH, readData,
    input  readStrobe, wordValid, wordAddress, wordData, pairError
  );
endinterface

// File: rtl/mux_bus_responder.sv
// Peripheral-side decoder for a multiplexed E/RW/AS CPU bus.
// The bus is oversampled on XTAL_IN. The address is latched on each AS fall.
// Write bytes are captured on E falls, and an address pair (A, A+1 in the
// low byte) is merged into one 16-bit word. Read cycles are answered by
// driving readData onto DATA_ADDR_LOW.
module mux_bus_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] ADDR_MASK = 16'h0000
) (
  input  logic               XTAL_IN,
  input  logic               RESET_N_IN,
  inout  wire  [7:0]         DATA_ADDR_LOW,
  mux_bus_responder_if.slave bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    HAVE_LOW = 1'b1
  } pair_state_e;

  // Synchronizer chains. Index 0 is the first flop and index 1 the
  // synchronized value. Index 2 is a delayed copy used for edge detection
  // and for the address/data that went with the last pre-edge sample.
  logic [2:0]      e_sync;
  logic [2:0]      as_sync;
  logic [1:0]      rw_sync;
  logic [2:0][7:0] adh_sync;
  logic [2:0][7:0] dal_sync;

  logic e_s, rw_s, as_s;
  logic e_fall, as_fall;

  logic [15:0] cur_addr;
  logic        addr_valid;
  logic        hit;

  logic        wr_evt;
  logic        rd_evt;
  logic [7:0]  wr_byte;
  logic [15:0] wr_addr;

  logic        drive_en;
  logic [7:0]  drive_data;

  pair_state_e state, state_next;
  logic [15:0] low_addr, low_addr_next;
  logic [7:0]  low_byte, low_byte_next;
  logic        word_valid, word_valid_next;
  logic        pair_error, pair_error_next;
  logic [15:0] word_addr, word_addr_next;
  logic [15:0] word_data, word_data_next;
  logic [7:0]  pair_lo;
  logic        pair_match;

  assign e_s     = e_sync[1];
  assign rw_s    = rw_sync[1];
  assign as_s    = as_sync[1];
  assign e_fall  = e_sync[2]  & ~e_sync[1];
  assign as_fall = as_sync[2] & ~as_sync[1];

  // Sample every bus input through matching synchronizer depths.
  // The reset presets leave no spurious edge when reset is released.
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      e_sync   <= 3'b111;
      as_sync  <= 3'b000;
      rw_sync  <= 2'b11;
      adh_sync <= '0;
      dal_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value. That is what makes this a shift chain and not
      // a single flop.
      e_sync   <= {e_sync[1:0], bus.E_IN};
      as_sync  <= {as_sync[1:0], bus.AS};
      rw_sync  <= {rw_sync[0], bus.RW};
      adh_sync <= {adh_sync[1:0], bus.AD_HIGH};
      dal_sync <= {dal_sync[1:0], DATA_ADDR_LOW};
    end
  end

  // Latch the address on AS fall. Any E fall consumes the latched address.
  // When both land in the same cycle, the set wins, so the new address
  // stays valid.
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      cur_addr   <= 16'h0000;
      addr_valid <= 1'b0;
    end else begin
      if (as_fall) begin
        cur_addr <= {adh_sync[2], dal_sync[2]};
      end
      if (as_fall) begin
        addr_valid <= 1'b1;
      end else if (e_fall) begin
        addr_valid <= 1'b0;
      end
    end
  end

  assign hit = ((cur_addr ^ BASE_ADDR) & ADDR_MASK) == 16'h0000;

  // Register the bus-cycle completion events. These use the address that
  // was current before any same-cycle AS fall, which gives E-first ordering.
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      wr_evt  <= 1'b0;
      rd_evt  <= 1'b0;
      wr_byte <= 8'h00;
      wr_addr <= 16'h0000;
    end else begin
      wr_evt <= e_fall & ~rw_s & addr_valid & hit;
      rd_evt <= e_fall &  rw_s & addr_valid & hit;
      if (e_fall) begin
        wr_byte <= dal_sync[2];
        wr_addr <= cur_addr;
      end
    end
  end

  // Drive the read byte during the data phase of a decoded read. The drive
  // is released one cycle after E drops, RW goes low or AS rises.
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      drive_en   <= 1'b0;
      drive_data <= 8'h00;
    end else begin
      drive_en   <= e_s & rw_s & ~as_s & addr_valid & hit;
      drive_data <= bus.readData;
    end
  end

  assign DATA_ADDR_LOW = drive_en ? drive_data : 8'bzzzz_zzzz;

  // The partner address keeps the high byte and wraps the low byte mod 256.
  assign pair_lo    = low_addr[7:0] + 8'd1;
  assign pair_match = (wr_addr == {low_addr[15:8], pair_lo});

  // Pairing decisions: merge A/A+1 writes, and flag a broken pair.
  always_comb begin
    // NOTE: every signal gets its hold value first. Any path that does not
    // assign it then still has a value, so no latch is inferred.
    state_next      = state;
    low_addr_next   = low_addr;
    low_byte_next   = low_byte;
    word_valid_next = 1'b0;
    pair_error_next = 1'b0;
    word_addr_next  = word_addr;
    word_data_next  = word_data;

    case (state)
      IDLE: begin
        if (wr_evt) begin
          low_addr_next = wr_addr;
          low_byte_next = wr_byte;
          state_next    = HAVE_LOW;
        end
      end
      HAVE_LOW: begin
        if (wr_evt) begin
          if (pair_match) begin
            word_valid_next = 1'b1;
            word_addr_next  = low_addr;
            word_data_next  = {wr_byte, low_byte};
            state_next      = IDLE;
          end else begin
            pair_error_next = 1'b1;
            low_addr_next   = wr_addr;
            low_byte_next   = wr_byte;
          end
        end else if (rd_evt) begin
          pair_error_next = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pairing state and registered word outputs. The word holds until the
  // next emit.
  always_ff @(posedge XTAL_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state      <= IDLE;
      low_addr   <= 16'h0000;
      low_byte   <= 8'h00;
      word_valid <= 1'b0;
      pair_error <= 1'b0;
      word_addr  <= 16'h0000;
      word_data  <= 16'h0000;
    end else begin
      state      <= state_next;
      low_addr   <= low_addr_next;
      low_byte   <= low_byte_next;
      word_valid <= word_valid_next;
      pair_error <= pair_error_next;
      word_addr  <= word_addr_next;
      word_data  <= word_data_next;
    end
  end

  assign bus.readStrobe  = rd_evt;
  assign bus.wordValid   = word_valid;
  assign bus.wordAddress = word_addr;
  assign bus.wordData    = word_data;
  assign bus.pairError   = pair_error;

endmodule

// File: tb/tb_mux_bus_responder.sv
// Testbench for mux_bus_responder. Two instances share one stimulus stream:
// dut0 decodes every address, and dut1 decodes only 0x8xxx.
// Each instance has its own bus wire with a pull-up, so a released bus
// reads 0xFF. Read bytes therefore never use 0xFF.
module tb_mux_bus_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_bus_responder_if if0 ();
  mux_bus_responder_if if1 ();

  wire  [7:0] bus0;
  wire  [7:0] bus1;
  logic       e_in, rw_in, as_in, tb_oe;
  logic [7:0] ad_high, tb_val, read_data;

  assign if0.E_IN     = e_in;
  assign if0.RW       = rw_in;
  assign if0.AS       = as_in;
  assign if0.AD_HIGH  = ad_high;
  assign if0.readData = read_data;
  assign if1.E_IN     = e_in;
  assign if1.RW       = rw_in;
  assign if1.AS       = as_in;
  assign if1.AD_HIGH  = ad_high;
  assign if1.readData = read_data;

  assign bus0 = tb_oe ? tb_val : 8'bzzzz_zzzz;
  assign bus1 = tb_oe ? tb_val : 8'bzzzz_zzzz;
  pullup pu0 (bus0);
  pullup pu1 (bus1);

  mux_bus_responder #(.BASE_ADDR(16'h0000), .ADDR_MASK(16'h0000)) dut0 (
    .XTAL_IN(clk), .RESET_N_IN(rst_n), .DATA_ADDR_LOW(bus0), .bus(if0)
  );
  mux_bus_responder #(.BASE_ADDR(16'h8000), .ADDR_MASK(16'hF000)) dut1 (
    .XTAL_IN(clk), .RESET_N_IN(rst_n), .DATA_ADDR_LOW(bus1), .bus(if1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor. It samples outputs on the falling clock edge.
  int cyc = 0;
  int wv_cnt[2];
  int pe_cnt[2];
  int rs_cnt[2];
  int last_wv_cyc[2];
  int drv1_cnt = 0;
  int fall_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (if0.wordValid) begin wv_cnt[0]++; last_wv_cyc[0] = cyc; end
    if (if1.wordValid) begin wv_cnt[1]++; last_wv_cyc[1] = cyc; end
    if (if0.pairError)  pe_cnt[0]++;
    if (if1.pairError)  pe_cnt[1]++;
    if (if0.readStrobe) rs_cnt[0]++;
    if (if1.readStrobe) rs_cnt[1]++;
    if (!tb_oe && bus1 !== 8'hFF) drv1_cnt++;
  end

  function automatic logic [15:0] get_waddr(input int d);
    return (d == 0) ? if0.wordAddress : if1.wordAddress;
  endfunction

  function automatic logic [15:0] get_wdata(input int d);
    return (d == 0) ? if0.wordData : if1.wordData;
  endfunction

  // Transaction-level reference model: one pending byte per instance.
  typedef struct {
    bit pending;
    int lo_addr;
    int lo_byte;
    int word_addr;
    int word_data;
  } model_t;

  model_t mdl[2];
  int base_of[2] = '{32'h0000, 32'h8000};
  int mask_of[2] = '{32'h0000, 32'hF000};
  int exp_wv[2];
  int exp_pe[2];
  int exp_rs[2];
  int wv_s[2];
  int pe_s[2];
  int rs_s[2];

  function automatic bit model_hit(input int addr, input int d);
    return ((addr ^ base_of[d]) & mask_of[d]) == 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mdl[d].pending   = 1'b0;
      mdl[d].word_addr = 0;
      mdl[d].word_data = 0;
    end
  endtask

  task automatic model_step(input int addr, input bit is_read, input int val);
    for (int d = 0; d < 2; d++) begin
      exp_wv[d] = 0;
      exp_pe[d] = 0;
      exp_rs[d] = 0;
      if (model_hit(addr, d)) begin
        if (is_read) begin
          exp_rs[d] = 1;
          if (mdl[d].pending) begin
            exp_pe[d] = 1;
            mdl[d].pending = 1'b0;
          end
        end else if (mdl[d].pending &&
                     (addr / 256) == (mdl[d].lo_addr / 256) &&
                     (addr % 256) == ((mdl[d].lo_addr % 256) + 1) % 256) begin
          exp_wv[d] = 1;
          mdl[d].word_addr = mdl[d].lo_addr;
          mdl[d].word_data = val * 256 + mdl[d].lo_byte;
          mdl[d].pending   = 1'b0;
        end else begin
          if (mdl[d].pending) exp_pe[d] = 1;
          mdl[d].pending = 1'b1;
          mdl[d].lo_addr = addr;
          mdl[d].lo_byte = val;
        end
      end
    end
  endtask

  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      wv_s[d] = wv_cnt[d];
      pe_s[d] = pe_cnt[d];
      rs_s[d] = rs_cnt[d];
    end
  endtask

  task automatic model_compare(input int d, input string tag);
    check($sformatf("%s dut%0d wordValid pulses", tag, d), wv_cnt[d] - wv_s[d], exp_wv[d]);
    check($sformatf("%s dut%0d pairError pulses", tag, d), pe_cnt[d] - pe_s[d], exp_pe[d]);
    check($sformatf("%s dut%0d readStrobe pulses", tag, d), rs_cnt[d] - rs_s[d], exp_rs[d]);
    check($sformatf("%s dut%0d wordAddress", tag, d), get_waddr(d), mdl[d].word_addr[15:0]);
    check($sformatf("%s dut%0d wordData", tag, d), get_wdata(d), mdl[d].word_data[15:0]);
  endtask

  // Address phase: E low, address on the bus, one AS pulse, then the bus
  // goes to write data or is released for a read.
  task automatic addr_phase(input logic [15:0] addr, input bit is_read, input logic [7:0] val);
    @(negedge clk);
    e_in    = 1'b0;
    rw_in   = is_read;
    ad_high = addr[15:8];
    tb_val  = addr[7:0];
    tb_oe   = 1'b1;
    as_in   = 1'b0;
    repeat (2) @(negedge clk);
    as_in = 1'b1;
    repeat (3) @(negedge clk);
    as_in = 1'b0;
    @(negedge clk);
    if (is_read) begin
      tb_oe     = 1'b0;
      read_data = val;
    end else begin
      tb_val = val;
    end
    repeat (3) @(negedge clk);
  endtask

  // One full bus cycle. Read cycles check the bus before, during and
  // after the data phase.
  task automatic bus_cycle(input logic [15:0] addr, input bit is_read, input logic [7:0] val);
    bit drv0, drv1;
    drv0 = is_read && model_hit(int'(addr), 0);
    drv1 = is_read && model_hit(int'(addr), 1);
    addr_phase(addr, is_read, val);
    if (is_read) begin
      check($sformatf("bus0 idle before E @%h", addr), bus0, 8'hFF);
      check($sformatf("bus1 idle before E @%h", addr), bus1, 8'hFF);
    end
    e_in = 1'b1;
    repeat (4) @(negedge clk);
    if (is_read) begin
      check($sformatf("bus0 read data @%h", addr), bus0, drv0 ? val : 8'hFF);
      check($sformatf("bus1 read data @%h", addr), bus1, drv1 ? val : 8'hFF);
    end
    @(negedge clk);
    e_in     = 1'b0;
    fall_cyc = cyc;
    repeat (4) @(negedge clk);
    if (is_read) begin
      check($sformatf("bus0 released @%h", addr), bus0, 8'hFF);
      check($sformatf("bus1 released @%h", addr), bus1, 8'hFF);
    end
    tb_oe = 1'b0;
    e_in  = 1'b1;
    rw_in = 1'b1;
    repeat (6) @(negedge clk);
    model_step(int'(addr), is_read, int'(val));
  endtask

  typedef struct {
    logic [15:0] addr;
    bit          is_read;
    logic [7:0]  val;
    int          wv;
    int          pe;
    int          rs;
    logic [15:0] waddr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [7:0]  hi_pick[4];
    logic [15:0] prev, addr;
    logic [7:0]  lo, val;
    bit          is_read;
    int          r;

    vt[0]  = '{16'h1234, 1'b0, 8'hEF, 0, 0, 0, 16'h0000, 16'h0000};
    vt[1]  = '{16'h1235, 1'b0, 8'hBE, 1, 0, 0, 16'h1234, 16'hBEEF};
    vt[2]  = '{16'h12FF, 1'b0, 8'h5A, 0, 0, 0, 16'h1234, 16'hBEEF};
    vt[3]  = '{16'h1200, 1'b0, 8'hA5, 1, 0, 0, 16'h12FF, 16'hA55A};
    vt[4]  = '{16'h2000, 1'b0, 8'h11, 0, 0, 0, 16'h12FF, 16'hA55A};
    vt[5]  = '{16'h3000, 1'b0, 8'h22, 0, 1, 0, 16'h12FF, 16'hA55A};
    vt[6]  = '{16'h3001, 1'b0, 8'h33, 1, 0, 0, 16'h3000, 16'h3322};
    vt[7]  = '{16'h4000, 1'b1, 8'h5C, 0, 0, 1, 16'h3000, 16'h3322};
    vt[8]  = '{16'h5000, 1'b0, 8'h01, 0, 0, 0, 16'h3000, 16'h3322};
    vt[9]  = '{16'h6000, 1'b1, 8'h77, 0, 1, 1, 16'h3000, 16'h3322};
    vt[10] = '{16'h5001, 1'b0, 8'h02, 0, 0, 0, 16'h3000, 16'h3322};
    vt[11] = '{16'h5002, 1'b0, 8'h03, 1, 0, 0, 16'h5001, 16'h0302};
    vt[12] = '{16'h8234, 1'b0, 8'hEF, 0, 0, 0, 16'h5001, 16'h0302};
    vt[13] = '{16'h8235, 1'b0, 8'hBE, 1, 0, 0, 16'h8234, 16'hBEEF};

    // Reset state.
    rst_n     = 1'b0;
    e_in      = 1'b1;
    rw_in     = 1'b1;
    as_in     = 1'b0;
    tb_oe     = 1'b0;
    tb_val    = 8'h00;
    ad_high   = 8'h00;
    read_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset wordValid",   if0.wordValid, 1'b0);
    check("reset pairError",   if0.pairError, 1'b0);
    check("reset readStrobe",  if0.readStrobe, 1'b0);
    check("reset wordAddress", if0.wordAddress, 16'h0000);
    check("reset wordData",    if0.wordData, 16'h0000);
    check("reset bus0 released", bus0, 8'hFF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table: dut0 against hand-derived values, dut1 against the model.
    for (int i = 0; i < 14; i++) begin
      snap();
      bus_cycle(vt[i].addr, vt[i].is_read, vt[i].val);
      check($sformatf("vec%0d wordValid pulses", i), wv_cnt[0] - wv_s[0], vt[i].wv);
      check($sformatf("vec%0d pairError pulses", i), pe_cnt[0] - pe_s[0], vt[i].pe);
      check($sformatf("vec%0d readStrobe pulses", i), rs_cnt[0] - rs_s[0], vt[i].rs);
      check($sformatf("vec%0d wordAddress", i), if0.wordAddress, vt[i].waddr);
      check($sformatf("vec%0d wordData", i), if0.wordData, vt[i].wdata);
      if (vt[i].wv == 1)
        check($sformatf("vec%0d wordValid latency", i), last_wv_cyc[0] - fall_cyc, 4);
      model_compare(1, $sformatf("vec%0d", i));
    end
    check("dut1 never drove bus", drv1_cnt, 0);
    check("dut1 word count", wv_cnt[1], 1);
    check("dut1 wordAddress", if1.wordAddress, 16'h8234);
    check("dut1 wordData", if1.wordData, 16'hBEEF);

    // Partial pair, then a reset in the middle of a read data phase.
    snap();
    bus_cycle(16'h0040, 1'b0, 8'h99);
    addr_phase(16'h4000, 1'b1, 8'h3C);
    e_in = 1'b1;
    repeat (4) @(negedge clk);
    check("pre-reset read drive", bus0, 8'h3C);
    #2 rst_n = 1'b0;
    #1 check("bus released on reset", bus0, 8'hFF);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset clears wordAddress", if0.wordAddress, 16'h0000);
    rst_n = 1'b1;
    e_in  = 1'b0;
    repeat (5) @(negedge clk);
    e_in  = 1'b1;
    rw_in = 1'b1;
    repeat (4) @(negedge clk);
    bus_cycle(16'h0010, 1'b0, 8'hAA);
    bus_cycle(16'h0011, 1'b0, 8'hBB);
    check("after reset wordValid count", wv_cnt[0] - wv_s[0], 1);
    check("after reset pairError count", pe_cnt[0] - pe_s[0], 0);
    check("after reset readStrobe count", rs_cnt[0] - rs_s[0], 0);
    check("after reset wordAddress", if0.wordAddress, 16'h0010);
    check("after reset wordData", if0.wordData, 16'hBBAA);

    // Randomized traffic against the model, biased toward A/A+1 pairs.
    hi_pick[0] = 8'h12;
    hi_pick[1] = 8'h80;
    hi_pick[2] = 8'h8F;
    hi_pick[3] = 8'h7F;
    prev = 16'h80FE;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        lo   = prev[7:0] + 8'd1;
        addr = {prev[15:8], lo};
      end else if (r < 7) begin
        addr = prev;
      end else if (r < 8) begin
        addr = {hi_pick[$urandom_range(0, 3)], 8'hFF};
      end else begin
        addr = {hi_pick[$urandom_range(0, 3)], 8'($urandom)};
      end
      is_read = ($urandom_range(0, 5) == 0);
      val = is_read ? 8'($urandom_range(0, 254)) : 8'($urandom_range(0, 255));
      snap();
      bus_cycle(addr, is_read, val);
      model_compare(0, $sformatf("rnd%0d", n));
      model_compare(1, $sformatf("rnd%0d", n));
      prev = addr;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
